// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/MEM memory-port arbiter: bus request/response structs,
// size encodings and the arbiter state enum.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int INSN_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [2:0] msize_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [INSN_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } mbus_req_t;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] data;
    } mbus_resp_t;

    // Instructions are 32-bit aligned inside the 64-bit memory word.
    function automatic logic [INSN_W-1:0] insn_select(input logic sel_hi,
                                                      input logic [DATA_W-1:0] word);
        return sel_hi ? word[DATA_W-1:INSN_W] : word[INSN_W-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, MEM and downstream memory buses around the arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mbus_req_t  mreq;
    mbus_resp_t mresp;

    modport master (
        input  ireq,
        input  dreq,
        input  mresp,
        output iresp,
        output dresp,
        output mreq
    );

    modport slave (
        output ireq,
        output dreq,
        output mresp,
        input  iresp,
        input  dresp,
        input  mreq
    );

endinterface

// File: rtl/mem_port_arbiter_req_hold.sv
// Holds the granted downstream request stable for the whole transaction,
// independent of what the requester does after the grant.
module mem_port_arbiter_req_hold
    import mem_port_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  mbus_req_t req_in,
    output mbus_req_t req_out
);

    mbus_req_t hold_d;
    mbus_req_t hold_q;

    always_comb begin
        hold_d = hold_q;
        if (load) begin
            hold_d = req_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign req_out = hold_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between fetch (ibus) and MEM (dbus); dbus has
// priority, but a streak limit guarantees fetch a grant after MAX_D_STREAK dbus wins.
//
//  state   | meaning
//  IDLE    | no transaction; arbitrate on the current requests
//  GRANT_I | fetch request held downstream until ready
//  GRANT_D | MEM request held downstream until ready
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_GRANT_I = GRANT_I;
    localparam logic [1:0] ST_GRANT_D = GRANT_D;

    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [1:0]          state_d;
    logic [1:0]          state_q;
    logic [STREAK_W-1:0] streak_d;
    logic [STREAK_W-1:0] streak_q;

    logic      d_wins;
    logic      hold_load;
    mbus_req_t hold_in;
    mbus_req_t hold_req;
    logic      granted;

    // Fetch only overrides the MEM stage once it has been passed over MAX_D_STREAK times.
    always_comb begin
        d_wins = bus.dreq.valid && !(bus.ireq.valid && (streak_q == STREAK_MAX));
    end

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        hold_load = 1'b0;
        hold_in   = '0;
        case (state_q)
            ST_IDLE: begin
                if (d_wins) begin
                    state_d          = ST_GRANT_D;
                    hold_load        = 1'b1;
                    hold_in.valid    = 1'b1;
                    hold_in.is_write = |bus.dreq.strobe;
                    hold_in.addr     = bus.dreq.addr;
                    hold_in.size     = bus.dreq.size;
                    hold_in.strobe   = bus.dreq.strobe;
                    hold_in.data     = bus.dreq.data;
                    if (bus.ireq.valid) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (bus.ireq.valid) begin
                    state_d       = ST_GRANT_I;
                    hold_load     = 1'b1;
                    hold_in.valid = 1'b1;
                    hold_in.addr  = bus.ireq.addr;
                    hold_in.size  = MSIZE4;
                    streak_d      = '0;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (bus.mresp.ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    mem_port_arbiter_req_hold u_req_hold (
        .clk     (clk),
        .reset   (reset),
        .load    (hold_load),
        .req_in  (hold_in),
        .req_out (hold_req)
    );

    always_comb begin
        granted = (state_q != ST_IDLE);
    end

    // valid follows the state directly so an async reset drops it at once.
    always_comb begin
        bus.mreq       = hold_req;
        bus.mreq.valid = hold_req.valid && granted;
    end

    always_comb begin
        bus.iresp = '0;
        bus.dresp = '0;
        if ((state_q == ST_GRANT_I) && bus.mresp.ready) begin
            bus.iresp.addr_ok = 1'b1;
            bus.iresp.data_ok = 1'b1;
            bus.iresp.data    = insn_select(hold_req.addr[2], bus.mresp.data);
        end
        if ((state_q == ST_GRANT_D) && bus.mresp.ready) begin
            bus.dresp.addr_ok = 1'b1;
            bus.dresp.data_ok = 1'b1;
            bus.dresp.data    = bus.mresp.data;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- reference model: who owns the port, what it sent ----------------
    int        m_owner;   // 0 none, 1 ibus, 2 dbus
    int        m_streak;
    mbus_req_t m_hold;

    function automatic mbus_req_t txn_from_d(input dbus_req_t r);
        mbus_req_t t;
        t          = '0;
        t.valid    = 1'b1;
        t.is_write = (r.strobe != 0);
        t.addr     = r.addr;
        t.size     = r.size;
        t.strobe   = r.strobe;
        t.data     = r.data;
        return t;
    endfunction

    function automatic mbus_req_t txn_from_i(input ibus_req_t r);
        mbus_req_t t;
        t       = '0;
        t.valid = 1'b1;
        t.addr  = r.addr;
        t.size  = MSIZE4;
        return t;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner  <= 0;
            m_streak <= 0;
        end else if (m_owner == 0) begin
            if (bus.dreq.valid && !(bus.ireq.valid && m_streak == MAXS)) begin
                m_owner  <= 2;
                m_hold   <= txn_from_d(bus.dreq);
                m_streak <= bus.ireq.valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (bus.ireq.valid) begin
                m_owner  <= 1;
                m_hold   <= txn_from_i(bus.ireq);
                m_streak <= 0;
            end
        end else if (bus.mresp.ready) begin
            m_owner <= 0;
        end
    end

    // ---------------- stimulus state ----------------
    bit              always_ready = 1'b0;
    int              lat = 0;
    int              mcnt = 0;
    logic [63:0]     iq[$];
    dbus_req_t       dq[$];

    // ---------------- observations ----------------
    int          cyc_n = 0;
    int          ipulses = 0;
    int          dpulses = 0;
    int          hist[$];
    int          pulse_cyc[$];
    int          rise_cyc[$];
    logic [31:0] last_idata = '0;
    mbus_req_t   prev_m = '0;
    bit          prev_live = 1'b0;
    bit          tb_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic dbus_req_t mk_d(input logic [63:0] addr, input msize_t size,
                                       input logic [7:0] strobe, input logic [63:0] data);
        dbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.addr   = addr;
        r.size   = size;
        r.strobe = strobe;
        r.data   = data;
        return r;
    endfunction

    task automatic compare_loop();
        bit ei;
        bit ed;
        while (!tb_done) begin
            @(negedge clk);
            cyc_n++;
            if (!reset) begin
                chk("rst_mreq_valid", bus.mreq.valid, 0);
                chk("rst_iresp_zero", bus.iresp, 0);
                chk("rst_dresp_zero", (bus.dresp == '0), 1);
                prev_live = 1'b0;
            end else begin
                chk("mreq_valid", bus.mreq.valid, (m_owner != 0));
                if (m_owner != 0) begin
                    chk("mreq_addr", bus.mreq.addr, m_hold.addr);
                    chk("mreq_is_write", bus.mreq.is_write, m_hold.is_write);
                    chk("mreq_size", bus.mreq.size, m_hold.size);
                    chk("mreq_strobe", bus.mreq.strobe, m_hold.strobe);
                    chk("mreq_data", bus.mreq.data, m_hold.data);
                end
                ei = (m_owner == 1) && bus.mresp.ready;
                ed = (m_owner == 2) && bus.mresp.ready;
                chk("i_data_ok", bus.iresp.data_ok, ei);
                chk("i_addr_ok", bus.iresp.addr_ok, ei);
                chk("d_data_ok", bus.dresp.data_ok, ed);
                chk("d_addr_ok", bus.dresp.addr_ok, ed);
                if (ei) chk("i_data", bus.iresp.data,
                            m_hold.addr[2] ? bus.mresp.data[63:32] : bus.mresp.data[31:0]);
                if (ed) chk("d_data", bus.dresp.data, bus.mresp.data);
                chk("single_data_ok", (bus.iresp.data_ok && bus.dresp.data_ok), 0);
                if (prev_live && prev_m.valid && bus.mreq.valid)
                    chk("mreq_stable", (bus.mreq == prev_m), 1);
                if (!prev_m.valid && bus.mreq.valid) rise_cyc.push_back(cyc_n);
                if (bus.iresp.data_ok) begin
                    ipulses++;
                    hist.push_back(1);
                    pulse_cyc.push_back(cyc_n);
                    last_idata = bus.iresp.data;
                end
                if (bus.dresp.data_ok) begin
                    dpulses++;
                    hist.push_back(2);
                    pulse_cyc.push_back(cyc_n);
                end
                prev_live = 1'b1;
            end
            prev_m = bus.mreq;
        end
    endtask

    // One clock: observe data_ok, then after the edge update memory and requesters.
    task automatic step();
        bit i_ok;
        bit d_ok;
        @(negedge clk);
        i_ok = bus.iresp.data_ok;
        d_ok = bus.dresp.data_ok;
        @(posedge clk);
        #1;
        if (!reset) begin
            bus.mresp.ready = 1'b0;
            mcnt = 0;
        end else if (always_ready) begin
            bus.mresp.ready = 1'b1;
        end else if (bus.mreq.valid) begin
            bus.mresp.ready = (mcnt == lat);
            mcnt++;
        end else begin
            bus.mresp.ready = 1'b0;
            mcnt = 0;
        end
        if (bus.ireq.valid && i_ok) bus.ireq.valid = 1'b0;
        if (!bus.ireq.valid && iq.size() > 0) begin
            bus.ireq.valid = 1'b1;
            bus.ireq.addr  = iq.pop_front();
        end
        if (bus.dreq.valid && d_ok) bus.dreq.valid = 1'b0;
        if (!bus.dreq.valid && dq.size() > 0) bus.dreq = dq.pop_front();
    endtask

    task automatic wait_pulses(input int ti, input int td, input int budget, input string name);
        int n;
        n = 0;
        while ((ipulses < ti || dpulses < td) && n < budget) begin
            step();
            n++;
        end
        chk(name, (ipulses >= ti && dpulses >= td), 1);
    endtask

    task automatic run_tests();
        int i0, d0, h0, p0, r0;
        int exp3[8];
        exp3 = '{2, 2, 2, 2, 1, 2, 2, 1};

        #1;
        chk("rst_lit_mvalid", bus.mreq.valid, 0);
        chk("rst_lit_iok", {bus.iresp.addr_ok, bus.iresp.data_ok}, 0);
        step();
        step();
        reset = 1'b1;
        step();

        // 1: lone fetch, ready after 3 cycles
        bus.mresp.data = 64'h1111_2222_3333_4444;
        lat = 3;
        i0 = ipulses; d0 = dpulses; p0 = pulse_cyc.size(); r0 = rise_cyc.size();
        iq.push_back(64'h8000_0004);
        step();
        chk("t1_valid_c0", bus.mreq.valid, 0);
        step();
        chk("t1_valid_c1", bus.mreq.valid, 1);
        chk("t1_addr", bus.mreq.addr, 64'h8000_0004);
        chk("t1_is_write", bus.mreq.is_write, 0);
        wait_pulses(i0 + 1, d0, 20, "t1_done");
        repeat (3) step();
        chk("t1_ipulses", ipulses - i0, 1);
        chk("t1_dpulses", dpulses - d0, 0);
        chk("t1_idata", last_idata, 32'h1111_2222);
        chk("t1_latency", pulse_cyc[p0] - rise_cyc[r0], 3);

        // 2: simultaneous store and fetch
        bus.mresp.data = 64'h0123_4567_89AB_CDEF;
        lat = 1;
        i0 = ipulses; d0 = dpulses; h0 = hist.size(); p0 = pulse_cyc.size(); r0 = rise_cyc.size();
        dq.push_back(mk_d(64'h8000_1000, MSIZE8, 8'hFF, 64'hDEAD_BEEF));
        iq.push_back(64'h8000_0010);
        step();
        step();
        chk("t2_first_is_write", bus.mreq.is_write, 1);
        chk("t2_first_addr", bus.mreq.addr, 64'h8000_1000);
        chk("t2_first_data", bus.mreq.data, 64'hDEAD_BEEF);
        wait_pulses(i0 + 1, d0 + 1, 30, "t2_done");
        chk("t2_order_d", hist[h0], 2);
        chk("t2_order_i", hist[h0 + 1], 1);
        chk("t2_idle_gap", rise_cyc[r0 + 1] - pulse_cyc[p0], 2);
        chk("t2_idata", last_idata, 32'h89AB_CDEF);

        // 3: dbus streak limit
        lat = 0;
        i0 = ipulses; d0 = dpulses; h0 = hist.size();
        for (int k = 0; k < 6; k++)
            dq.push_back(mk_d(64'h8000_4000 + 64'(k * 8), MSIZE8,
                              (k % 2 == 1) ? 8'h0F : 8'h00, 64'h1000 + 64'(k)));
        iq.push_back(64'h8000_2000);
        iq.push_back(64'h8000_2004);
        wait_pulses(i0 + 2, d0 + 6, 80, "t3_done");
        for (int k = 0; k < 8; k++) chk("t3_grant_seq", hist[h0 + k], exp3[k]);
        chk("t3_model_streak", m_streak, 0);

        // 4: reset in the middle of a dbus grant
        lat = 10;
        d0 = dpulses;
        dq.push_back(mk_d(64'h8000_3000, MSIZE4, 8'h00, 64'h0));
        step();
        step();
        step();
        chk("t4_pre_valid", bus.mreq.valid, 1);
        reset = 1'b0;
        #1;
        chk("t4_async_valid", bus.mreq.valid, 0);
        chk("t4_no_dok", bus.dresp.data_ok, 0);
        bus.dreq = '0;
        bus.ireq = '0;
        dq.delete();
        iq.delete();
        step();
        step();
        reset = 1'b1;
        repeat (6) step();
        chk("t4_no_pulse", dpulses - d0, 0);
        chk("t4_idle_after", bus.mreq.valid, 0);

        // 5: ready stuck high, fetch only
        always_ready = 1'b1;
        bus.mresp.data = 64'hAAAA_BBBB_CCCC_DDDD;
        i0 = ipulses; p0 = pulse_cyc.size(); r0 = rise_cyc.size();
        for (int k = 0; k < 6; k++) iq.push_back(64'h8000_5000 + 64'(k * 4));
        wait_pulses(i0 + 6, dpulses, 40, "t5_done");
        for (int k = 1; k < 6; k++) chk("t5_spacing", pulse_cyc[p0 + k] - pulse_cyc[p0 + k - 1], 2);
        repeat (4) step();
        chk("t5_count", ipulses - i0, 6);
        chk("t5_grants", rise_cyc.size() - r0, 6);
        chk("t5_last_idata", last_idata, 32'hAAAA_BBBB);
        always_ready = 1'b0;

        // 6: requester drops valid mid-grant; held copy still completes
        lat = 2;
        d0 = dpulses;
        dq.push_back(mk_d(64'h8000_6008, MSIZE2, 8'h0C, 64'h5555_6666));
        step();
        step();
        chk("t6_strobe", bus.mreq.strobe, 8'h0C);
        chk("t6_is_write", bus.mreq.is_write, 1);
        bus.dreq.valid = 1'b0;
        wait_pulses(ipulses, d0 + 1, 20, "t6_done");
        repeat (3) step();
        chk("t6_one_pulse", dpulses - d0, 1);
    endtask

    initial begin
        bus.ireq  = '0;
        bus.dreq  = '0;
        bus.mresp = '0;
        fork
            compare_loop();
            begin
                run_tests();
                tb_done = 1'b1;
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
